// File: rtl/ring_fifo_drain_tx_if.sv
// Egress FIFO read port plus ring link bundle for ring_fifo_drain_tx.
// master = transmitter side, slave = FIFO/link/environment side.
interface ring_fifo_drain_tx_if #(
  parameter int WIDTH = 8
);
  logic             iEn;
  logic             iEmpty;
  logic [1:0]       iDatVld;
  logic [WIDTH-1:0] iRdDat;
  logic             oRdEn;
  logic             oLinkVld;
  logic [WIDTH-1:0] oLinkDat;
  logic             oLinkPar;
  logic             iCreditRet;
  logic [3:0]       oCreditCnt;
  logic [1:0]       oState;
  logic             oErr;

  modport master (
    input  iEn, iEmpty, iDatVld, iRdDat, iCreditRet,
    output oRdEn, oLinkVld, oLinkDat, oLinkPar, oCreditCnt, oState, oErr
  );

  modport slave (
    output iEn, iEmpty, iDatVld, iRdDat, iCreditRet,
    input  oRdEn, oLinkVld, oLinkDat, oLinkPar, oCreditCnt, oState, oErr
  );
endinterface

// File: rtl/ring_fifo_drain_tx.sv
// Credit-flow ring link transmitter draining a show-ahead egress FIFO.
// Optional RING_TX_PARITY_EN: registered link parity plus credit-overflow valid guard.
module ring_fifo_drain_tx #(
  parameter int WIDTH   = 8,
  parameter int CREDITS = 2
) (
  input  logic clk,
  input  logic rst,
  ring_fifo_drain_tx_if.master tx
);
  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, STALL = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cred_q, cred_d;
  logic             err_q, err_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q;
  logic             send, ret_full, fifo_bad;

  assign send     = tx.iEn & ~tx.iEmpty & (cred_q != 4'd0);
  assign ret_full = tx.iCreditRet & (cred_q == CRED_MAX);
  assign fifo_bad = (~tx.iEmpty & (tx.iDatVld == 2'd0)) | (tx.iEmpty & (tx.iDatVld != 2'd0));

  always_comb begin
    state_d = IDLE;
    cred_d  = cred_q;
    err_d   = err_q | fifo_bad;
    vld_d   = send;
    if (send)
      state_d = SEND;
    else if (tx.iEn & ~tx.iEmpty)
      state_d = STALL;
    // A return arriving alongside a send leaves the count unchanged.
    if (send & ~tx.iCreditRet)
      cred_d = cred_q - 4'd1;
    else if (tx.iCreditRet & ~send) begin
      if (ret_full) err_d = 1'b1;
      else          cred_d = cred_q + 4'd1;
    end
`ifdef RING_TX_PARITY_EN
    if (ret_full) vld_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cred_q  <= CRED_MAX;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      if (send) dat_q <= tx.iRdDat;
    end
  end

`ifdef RING_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       par_q <= 1'b0;
    else if (send) par_q <= ^tx.iRdDat;
  end
  assign tx.oLinkPar = par_q;
`else
  assign tx.oLinkPar = 1'b0;
`endif

  assign tx.oRdEn      = send;
  assign tx.oLinkVld   = vld_q;
  assign tx.oLinkDat   = dat_q;
  assign tx.oCreditCnt = cred_q;
  assign tx.oState     = state_q;
  assign tx.oErr       = err_q;
endmodule

// File: tb/tb_ring_fifo_drain_tx.sv
// Scoreboard bench for ring_fifo_drain_tx: FIFO model feeds the DUT, credit/FSM model predicts outputs.
module tb_ring_fifo_drain_tx;
  localparam int W = 8;
  localparam int C = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ring_fifo_drain_tx_if #(.WIDTH(W)) bus ();
  ring_fifo_drain_tx #(.WIDTH(W), .CREDITS(C)) dut (.clk(clk), .rst(rst), .tx(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] fifo[$];
  logic [W:0]   expq[$];
  int           mcred;
  logic         merr, exp_vld, en, bad_dv;
  logic [1:0]   mstate;

  task automatic model_reset();
    mcred = C; merr = 1'b0; exp_vld = 1'b0; mstate = 2'd0;
    expq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; bad_dv = 1'b0;
    fifo.delete();
    bus.iEn = 1'b0; bus.iEmpty = 1'b1; bus.iDatVld = 2'd0; bus.iRdDat = '0; bus.iCreditRet = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive at negedge, check pop, advance model at posedge, check outputs.
  task automatic cyc(input logic ret);
    logic nonempty, snd, full;
    logic [W-1:0] hd;
    logic [W:0] e;
    @(negedge clk);
    nonempty = (fifo.size() != 0);
    hd = nonempty ? fifo[0] : '0;
    bus.iEn = en; bus.iEmpty = ~nonempty; bus.iRdDat = hd; bus.iCreditRet = ret;
    bus.iDatVld = bad_dv ? (nonempty ? 2'd0 : 2'd1) : 2'(fifo.size());
    snd  = en & nonempty & (mcred != 0);
    full = ret & (mcred == C);
    #1;
    n_cmp++;
    if (bus.oRdEn !== snd) begin n_bad++; $display("FAIL rd_en: got %b want %b", bus.oRdEn, snd); end
    @(posedge clk);
    if (snd && !ret) mcred--;
    else if (ret && !snd && mcred < C) mcred++;
    merr = merr | (full & ~snd) | bad_dv;
    mstate = snd ? 2'd1 : (en && nonempty) ? 2'd2 : 2'd0;
`ifdef RING_TX_PARITY_EN
    exp_vld = snd & ~full;
`else
    exp_vld = snd;
`endif
    if (snd) void'(fifo.pop_front());
    if (exp_vld) expq.push_back({^hd, hd});
    #1;
    n_cmp++;
    if (bus.oLinkVld !== exp_vld) begin n_bad++; $display("FAIL link_vld: got %b want %b", bus.oLinkVld, exp_vld); end
    n_cmp++;
    if (bus.oCreditCnt !== 4'(mcred)) begin n_bad++; $display("FAIL credit_cnt: got %0d want %0d", bus.oCreditCnt, mcred); end
    n_cmp++;
    if (bus.oState !== mstate) begin n_bad++; $display("FAIL state: got %0d want %0d", bus.oState, mstate); end
    n_cmp++;
    if (bus.oErr !== merr) begin n_bad++; $display("FAIL err: got %b want %b", bus.oErr, merr); end
    if (bus.oLinkVld === 1'b1) begin
      n_cmp++;
      if (expq.size() == 0) begin
        n_bad++; $display("FAIL link_dat: got %0h want none (scoreboard empty)", bus.oLinkDat);
      end else begin
        e = expq.pop_front();
        if (bus.oLinkDat !== e[W-1:0]) begin n_bad++; $display("FAIL link_dat: got %0h want %0h", bus.oLinkDat, e[W-1:0]); end
`ifdef RING_TX_PARITY_EN
        n_cmp++;
        if (bus.oLinkPar !== e[W]) begin n_bad++; $display("FAIL link_par: got %b want %b", bus.oLinkPar, e[W]); end
`endif
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.oLinkVld, bus.oLinkDat, bus.oLinkPar, bus.oRdEn, bus.oErr} !== 12'h0 ||
        bus.oCreditCnt !== 4'd2 || bus.oState !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_vals: got vld=%b dat=%0h par=%b rd=%b cnt=%0d st=%0d err=%b want 0/0/0/0/2/0/0",
               bus.oLinkVld, bus.oLinkDat, bus.oLinkPar, bus.oRdEn, bus.oCreditCnt, bus.oState, bus.oErr);
    end
    @(negedge clk); rst = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b0);
  endtask

  task automatic test_burst();
    en = 1'b1;
    fifo.push_back(8'h11); fifo.push_back(8'h12);
    cyc(1'b0);
    n_cmp++;
    if (bus.oLinkDat !== 8'h11 || bus.oCreditCnt !== 4'd1) begin
      n_bad++; $display("FAIL burst_first: got dat=%0h cnt=%0d want 11/1", bus.oLinkDat, bus.oCreditCnt);
    end
    cyc(1'b0);
    n_cmp++;
    if (bus.oLinkDat !== 8'h12 || bus.oCreditCnt !== 4'd0) begin
      n_bad++; $display("FAIL burst_second: got dat=%0h cnt=%0d want 12/0", bus.oLinkDat, bus.oCreditCnt);
    end
    fifo.push_back(8'h13);
    cyc(1'b0);
    n_cmp++;
    if (bus.oState !== 2'd2) begin n_bad++; $display("FAIL burst_stall: got %0d want 2", bus.oState); end
  endtask

  task automatic test_credit_ret();
    cyc(1'b1);
    n_cmp++;
    if (bus.oCreditCnt !== 4'd1 || bus.oLinkVld !== 1'b0) begin
      n_bad++; $display("FAIL ret_blocked: got cnt=%0d vld=%b want 1/0", bus.oCreditCnt, bus.oLinkVld);
    end
    cyc(1'b0);
    n_cmp++;
    if (bus.oLinkVld !== 1'b1 || bus.oLinkDat !== 8'h13 || bus.oCreditCnt !== 4'd0) begin
      n_bad++; $display("FAIL ret_send: got vld=%b dat=%0h cnt=%0d want 1/13/0", bus.oLinkVld, bus.oLinkDat, bus.oCreditCnt);
    end
  endtask

  task automatic test_same_cycle();
    cyc(1'b1);
    fifo.push_back(8'h21); fifo.push_back(8'h22);
    cyc(1'b1);
    n_cmp++;
    if (bus.oCreditCnt !== 4'd1 || bus.oLinkDat !== 8'h21) begin
      n_bad++; $display("FAIL same_cycle: got cnt=%0d dat=%0h want 1/21", bus.oCreditCnt, bus.oLinkDat);
    end
    cyc(1'b0);
    n_cmp++;
    if (bus.oLinkDat !== 8'h22 || bus.oCreditCnt !== 4'd0) begin
      n_bad++; $display("FAIL same_cycle_next: got dat=%0h cnt=%0d want 22/0", bus.oLinkDat, bus.oCreditCnt);
    end
  endtask

  task automatic test_overflow();
    cyc(1'b1); cyc(1'b1);
    n_cmp++;
    if (bus.oCreditCnt !== 4'd2 || bus.oErr !== 1'b0) begin
      n_bad++; $display("FAIL ovf_pre: got cnt=%0d err=%b want 2/0", bus.oCreditCnt, bus.oErr);
    end
    cyc(1'b1);
    n_cmp++;
    if (bus.oCreditCnt !== 4'd2 || bus.oErr !== 1'b1) begin
      n_bad++; $display("FAIL ovf: got cnt=%0d err=%b want 2/1", bus.oCreditCnt, bus.oErr);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0);
    fifo.push_back(8'h01); fifo.push_back(8'h03);
    cyc(1'b0);
`ifdef RING_TX_PARITY_EN
    n_cmp++;
    if (bus.oLinkPar !== 1'b1) begin n_bad++; $display("FAIL par_01: got %b want 1", bus.oLinkPar); end
`endif
    cyc(1'b0);
`ifdef RING_TX_PARITY_EN
    n_cmp++;
    if (bus.oLinkPar !== 1'b0) begin n_bad++; $display("FAIL par_03: got %b want 0", bus.oLinkPar); end
`endif
    n_cmp++;
    if (bus.oErr !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", bus.oErr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1;
    fifo.push_back(8'h31); fifo.push_back(8'h32);
    cyc(1'b0); cyc(1'b0);
    n_cmp++;
    if (bus.oLinkVld !== 1'b1 || bus.oCreditCnt !== 4'd0) begin
      n_bad++; $display("FAIL mid_pre: got vld=%b cnt=%0d want 1/0", bus.oLinkVld, bus.oCreditCnt);
    end
    en = 1'b0; bus.iEn = 1'b0;
    fifo.push_back(8'h33);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.oLinkVld !== 1'b0 || bus.oCreditCnt !== 4'd2) begin
      n_bad++; $display("FAIL mid_rst: got vld=%b cnt=%0d want 0/2", bus.oLinkVld, bus.oCreditCnt);
    end
    @(negedge clk); rst = 1'b0;
    model_reset();
    en = 1'b1;
    cyc(1'b0);
    n_cmp++;
    if (bus.oLinkDat !== 8'h33) begin n_bad++; $display("FAIL mid_resume: got %0h want 33", bus.oLinkDat); end
  endtask

  task automatic test_consistency();
    do_reset();
    bad_dv = 1'b1;
    cyc(1'b0);
    bad_dv = 1'b0;
    n_cmp++;
    if (bus.oErr !== 1'b1) begin n_bad++; $display("FAIL cons_empty: got %b want 1", bus.oErr); end
    do_reset();
    fifo.push_back(8'h44);
    bad_dv = 1'b1;
    cyc(1'b0);
    bad_dv = 1'b0;
    n_cmp++;
    if (bus.oErr !== 1'b1) begin n_bad++; $display("FAIL cons_full: got %b want 1", bus.oErr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if (fifo.size() < 2 && $urandom_range(0, 9) < 7) fifo.push_back(8'($urandom));
      cyc($urandom_range(0, 9) < 4);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_credit_ret();
    test_same_cycle();
    test_overflow();
    test_reset_mid();
    test_consistency();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
